result_drain_fifo: RTL



---
 rtl/img_acc_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/result_drain_fifo.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/img_acc_pkg.sv
// Shared types and helpers for the image accelerator result path.
// Holds the drain FSM state encoding, default sizing and the lane byte-swap helper.
package img_acc_pkg;

  localparam int DRN_DW_DEF         = 32;
  localparam int DRN_DEPTH_DEF      = 16;
  localparam int DRN_BURST_LEN_DEF  = 8;
  localparam int DRN_FLUSH_IDLE_DEF = 4;

  typedef enum logic [1:0] {
    DRN_IDLE   = 2'd0,
    DRN_STREAM = 2'd1,
    DRN_FLUSH  = 2'd2,
    DRN_DONE   = 2'd3
  } drn_state_e;

  // Reverse the byte order of one 32-bit lane (big-endian consumers).
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full/empty/count decode straight from the pointers.
// Callers gate push_i with !full_o and pop_i with !empty_o.
module sync_fifo
  import img_acc_pkg::*;
#(
  parameter int DW    = DRN_DW_DEF,
  parameter int DEPTH = DRN_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;

endmodule

// File: rtl/result_drain_fifo.sv
// Captures processed words into a FIFO and drains them over valid/ready with burst marking.
// Build option DRAIN_BYTE_SWAP_EN byte-reverses each 32-bit lane as it enters the output register.
//
// state      | meaning
// DRN_IDLE   | no frame open, waiting for the first accepted write
// DRN_STREAM | frame open, draining, waiting for proc_cmplt
// DRN_FLUSH  | proc_cmplt seen, draining until FLUSH_IDLE quiet cycles
// DRN_DONE   | drain_done pulse, back to idle
module result_drain_fifo
  import img_acc_pkg::*;
#(
  parameter int DW         = DRN_DW_DEF,
  parameter int DEPTH      = DRN_DEPTH_DEF,
  parameter int BURST_LEN  = DRN_BURST_LEN_DEF,
  parameter int FLUSH_IDLE = DRN_FLUSH_IDLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          data_fifo,
  input  logic                   wr,
  input  logic                   proc_cmplt,
  output logic [DW-1:0]          mstx_data,
  output logic                   mstx_valid,
  input  logic                   mstx_ready,
  output logic                   mstx_last,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   drain_done,
  output logic                   overflow,
  output logic [31:0]            word_count
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int IW = $clog2(FLUSH_IDLE + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_IDLE - 1);

  logic          fifo_empty;
  logic [DW-1:0] fifo_head;
  logic          push;
  logic          drop;
  logic          pop;
  logic          hs;
  logic          quiet;

  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;
  logic          valid_q;

  drn_state_e    state_q;
  logic [BW-1:0] burst_q;
  logic [IW-1:0] idle_q;
  logic [31:0]   word_q;
  logic          ovf_q;
  logic          done_q;

  assign push  = wr && !fifo_full;
  assign drop  = wr && fifo_full;
  assign hs    = valid_q && mstx_ready;
  assign pop   = !fifo_empty && (!valid_q || hs);
  assign quiet = fifo_empty && !valid_q && !wr;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (data_fifo),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef DRAIN_BYTE_SWAP_EN
  always_comb begin
    data_d = '0;
    for (int l = 0; l < DW / 32; l++) begin
      data_d[l*32 +: 32] = bswap32(fifo_head[l*32 +: 32]);
    end
  end
`else
  assign data_d = fifo_head;
`endif

  // Output stage refills in the same cycle a beat is accepted, so a steady
  // stream sustains one beat per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      data_q  <= data_d;
      valid_q <= 1'b1;
    end else if (hs) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRN_IDLE;
      burst_q <= '0;
      idle_q  <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (hs) begin
        burst_q <= burst_q + 1'b1;
        word_q  <= word_q + 32'd1;
      end
      if (drop) ovf_q <= 1'b1;

      case (state_q)
        DRN_IDLE, DRN_DONE: begin
          // A write landing in the DONE cycle opens the next frame directly.
          if (push) begin
            state_q <= DRN_STREAM;
            ovf_q   <= 1'b0;
            word_q  <= '0;
            burst_q <= '0;
            idle_q  <= '0;
          end else begin
            state_q <= DRN_IDLE;
          end
        end
        DRN_STREAM: begin
          if (proc_cmplt) begin
            state_q <= DRN_FLUSH;
            idle_q  <= '0;
          end
        end
        DRN_FLUSH: begin
          if (quiet) begin
            if (idle_q == IDLE_LAST) begin
              state_q <= DRN_DONE;
              done_q  <= 1'b1;
              idle_q  <= '0;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end else begin
            idle_q <= '0;
          end
        end
        default: state_q <= DRN_IDLE;
      endcase
    end
  end

  assign mstx_data  = data_q;
  assign mstx_valid = valid_q;
  assign mstx_last  = valid_q && (burst_q == BURST_MAX);
  assign drain_done = done_q;
  assign overflow   = ovf_q;
  assign word_count = word_q;

endmodule
